// File: rtl/gci_hub_specialmem_scanner.sv
// gci_hub_specialmem_scanner
// This block is the initiator side of the hub special-memory read port.
// On iSTART it reads the node count, the total-size word and each node's
// size and priority words. It then packs the node bases one after another,
// starting right after the special area.
// Optional build macro: GCI_SCAN_TIMEOUT_EN adds a response watchdog that
// ends a stalled scan with error code 3.
module gci_hub_specialmem_scanner #(
    parameter logic [31:0] P_SPECIAL_SIZE = 32'h400,
    parameter int          P_NODE_MAX     = 4
`ifdef GCI_SCAN_TIMEOUT_EN
    ,
    parameter int          P_TIMEOUT      = 255
`endif
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iSTART,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERROR,
    output logic [1:0]  oERR_CODE,
    output logic        oREQ,
    output logic [9:0]  oREQ_ADDR,
    input  logic        iREQ_BUSY,
    input  logic        iRD_VALID,
    input  logic [31:0] iRD_DATA,
    output logic [3:0]  oNODE_VALID,
    output logic [31:0] oNODE1_BASE,
    output logic [31:0] oNODE2_BASE,
    output logic [31:0] oNODE3_BASE,
    output logic [31:0] oNODE4_BASE,
    output logic [31:0] oNODE1_SIZE,
    output logic [31:0] oNODE2_SIZE,
    output logic [31:0] oNODE3_SIZE,
    output logic [31:0] oNODE4_SIZE,
    output logic [7:0]  oNODE1_PRIORITY,
    output logic [7:0]  oNODE2_PRIORITY,
    output logic [7:0]  oNODE3_PRIORITY,
    output logic [7:0]  oNODE4_PRIORITY
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK} state_t;
    typedef enum logic [1:0] {PH_COUNT, PH_TOTAL, PH_SIZE, PH_PRIO} phase_t;

    state_t      state;
    state_t      next_state;
    phase_t      phase;
    logic [1:0]  node_idx;
    logic [2:0]  node_cnt;
    logic [31:0] acc;
    logic [31:0] total;
    logic [1:0]  err_q;
    logic [1:0]  final_code;
    logic        capture;
    logic        bad_count;
    logic        last_read;
    logic        start;

    logic [31:0] node_base [4];
    logic [31:0] node_size [4];
    logic [7:0]  node_prio [4];
    logic [3:0]  node_valid;

`ifdef GCI_SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(P_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;
    assign timeout_hit = (state == S_WAIT) && !iRD_VALID
                         && (to_cnt == TO_W'(P_TIMEOUT - 1));
`endif

    assign start     = (state == S_IDLE) && iSTART;
    assign bad_count = (iRD_DATA == 32'd0) || (iRD_DATA > 32'(P_NODE_MAX));
    assign last_read = (phase == PH_PRIO) && ({1'b0, node_idx} == node_cnt - 3'd1);
    // The mismatch check only applies when the scan reached CHECK cleanly
    assign final_code = ((err_q == 2'd0) && (acc != total)) ? 2'd2 : err_q;

    // State register; an asynchronous reset abandons any scan in progress
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic plus handshake and status outputs
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        oREQ       = 1'b0;
        oREQ_ADDR  = 10'd0;
        oDONE      = 1'b0;
        oBUSY      = (state != S_IDLE);
        oERR_CODE  = err_q;
        case (state)
            S_IDLE: begin
                if (iSTART) next_state = S_REQ;
            end
            S_REQ: begin
                oREQ = 1'b1;
                case (phase)
                    PH_COUNT: oREQ_ADDR = 10'h000;
                    PH_TOTAL: oREQ_ADDR = 10'h004;
                    PH_SIZE:  oREQ_ADDR = 10'h100 + {3'd0, node_idx, 5'd0};
                    default:  oREQ_ADDR = 10'h104 + {3'd0, node_idx, 5'd0};
                endcase
                if (!iREQ_BUSY) begin
                    if (iRD_VALID) begin
                        capture = 1'b1;
                        if (((phase == PH_COUNT) && bad_count) || last_read) next_state = S_CHECK;
                        else                                                  next_state = S_REQ;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (iRD_VALID) begin
                    capture = 1'b1;
                    if (((phase == PH_COUNT) && bad_count) || last_read) next_state = S_CHECK;
                    else                                                  next_state = S_REQ;
                end
`ifdef GCI_SCAN_TIMEOUT_EN
                else if (timeout_hit) begin
                    next_state = S_CHECK;
                end
`endif
            end
            S_CHECK: begin
                oDONE      = 1'b1;
                oERR_CODE  = final_code;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign oERROR = (oERR_CODE != 2'd0);

    // Read sequencing, node map construction and error bookkeeping
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            phase      <= PH_COUNT;
            node_idx   <= 2'd0;
            node_cnt   <= 3'd0;
            acc        <= 32'd0;
            total      <= 32'd0;
            err_q      <= 2'd0;
            node_valid <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                node_base[i] <= 32'd0;
                node_size[i] <= 32'd0;
                node_prio[i] <= 8'd0;
            end
        end else begin
            if (start) begin
                phase      <= PH_COUNT;
                node_idx   <= 2'd0;
                node_cnt   <= 3'd0;
                acc        <= P_SPECIAL_SIZE;
                total      <= 32'd0;
                err_q      <= 2'd0;
                node_valid <= 4'd0;
                for (int i = 0; i < 4; i++) begin
                    node_base[i] <= 32'd0;
                    node_size[i] <= 32'd0;
                    node_prio[i] <= 8'd0;
                end
            end else if (capture) begin
                case (phase)
                    PH_COUNT: begin
                        if (bad_count) begin
                            err_q <= 2'd1;
                        end else begin
                            node_cnt <= iRD_DATA[2:0];
                            phase    <= PH_TOTAL;
                        end
                    end
                    PH_TOTAL: begin
                        total    <= iRD_DATA;
                        node_idx <= 2'd0;
                        phase    <= PH_SIZE;
                    end
                    PH_SIZE: begin
                        node_base[node_idx]  <= acc;
                        node_size[node_idx]  <= iRD_DATA;
                        node_valid[node_idx] <= 1'b1;
                        acc                  <= acc + iRD_DATA;
                        phase                <= PH_PRIO;
                    end
                    default: begin
                        node_prio[node_idx] <= iRD_DATA[7:0];
                        node_idx            <= node_idx + 2'd1;
                        phase               <= PH_SIZE;
                    end
                endcase
            end
`ifdef GCI_SCAN_TIMEOUT_EN
            else if (timeout_hit) begin
                err_q <= 2'd3;
            end
`endif
            if (state == S_CHECK) err_q <= final_code;
        end
    end

`ifdef GCI_SCAN_TIMEOUT_EN
    // Watchdog restarts on every accepted request and runs only while waiting
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)                                 to_cnt <= '0;
        else if ((state == S_REQ) && !iREQ_BUSY)    to_cnt <= '0;
        else if ((state == S_WAIT) && !iRD_VALID)   to_cnt <= to_cnt + 1'b1;
    end
`endif

    assign oNODE_VALID     = node_valid;
    assign oNODE1_BASE     = node_base[0];
    assign oNODE2_BASE     = node_base[1];
    assign oNODE3_BASE     = node_base[2];
    assign oNODE4_BASE     = node_base[3];
    assign oNODE1_SIZE     = node_size[0];
    assign oNODE2_SIZE     = node_size[1];
    assign oNODE3_SIZE     = node_size[2];
    assign oNODE4_SIZE     = node_size[3];
    assign oNODE1_PRIORITY = node_prio[0];
    assign oNODE2_PRIORITY = node_prio[1];
    assign oNODE3_PRIORITY = node_prio[2];
    assign oNODE4_PRIORITY = node_prio[3];

endmodule

// File: tb/tb_gci_hub_specialmem_scanner.sv
// tb_gci_hub_specialmem_scanner
// This bench applies directed scans to the scanner through a bench-side
// special-memory responder. The responder can stall requests with busy
// cycles and can delay its responses.
// Build macro GCI_SCAN_TIMEOUT_EN also enables the watchdog scenario.
module tb_gci_hub_specialmem_scanner;

    logic        iCLOCK = 1'b0;
    logic        iRESET = 1'b1;
    logic        iSTART = 1'b0;
    logic        oBUSY, oDONE, oERROR, oREQ;
    logic [1:0]  oERR_CODE;
    logic [9:0]  oREQ_ADDR;
    logic        iREQ_BUSY = 1'b0;
    logic        iRD_VALID = 1'b0;
    logic [31:0] iRD_DATA  = 32'd0;
    logic [3:0]  oNODE_VALID;
    logic [31:0] oNODE1_BASE, oNODE2_BASE, oNODE3_BASE, oNODE4_BASE;
    logic [31:0] oNODE1_SIZE, oNODE2_SIZE, oNODE3_SIZE, oNODE4_SIZE;
    logic [7:0]  oNODE1_PRIORITY, oNODE2_PRIORITY, oNODE3_PRIORITY, oNODE4_PRIORITY;

    int checks = 0;
    int errors = 0;

    // Bench memory image and expected node map
    logic [31:0] m_cnt, m_total;
    logic [31:0] m_size [4];
    logic [31:0] m_prio [4];
    logic [31:0] e_base [4];
    logic [31:0] e_size [4];
    logic [7:0]  e_prio [4];
    logic [3:0]  e_valid;
    logic [9:0]  addr_log [16];
    logic [31:0] a_base [4];
    logic [31:0] a_size [4];
    logic [7:0]  a_prio [4];
    int          nreads;
    bit          done_seen;

    gci_hub_specialmem_scanner dut (
        .iCLOCK(iCLOCK), .iRESET(iRESET), .iSTART(iSTART),
        .oBUSY(oBUSY), .oDONE(oDONE), .oERROR(oERROR), .oERR_CODE(oERR_CODE),
        .oREQ(oREQ), .oREQ_ADDR(oREQ_ADDR), .iREQ_BUSY(iREQ_BUSY),
        .iRD_VALID(iRD_VALID), .iRD_DATA(iRD_DATA), .oNODE_VALID(oNODE_VALID),
        .oNODE1_BASE(oNODE1_BASE), .oNODE2_BASE(oNODE2_BASE),
        .oNODE3_BASE(oNODE3_BASE), .oNODE4_BASE(oNODE4_BASE),
        .oNODE1_SIZE(oNODE1_SIZE), .oNODE2_SIZE(oNODE2_SIZE),
        .oNODE3_SIZE(oNODE3_SIZE), .oNODE4_SIZE(oNODE4_SIZE),
        .oNODE1_PRIORITY(oNODE1_PRIORITY), .oNODE2_PRIORITY(oNODE2_PRIORITY),
        .oNODE3_PRIORITY(oNODE3_PRIORITY), .oNODE4_PRIORITY(oNODE4_PRIORITY)
    );

    always #5 iCLOCK = ~iCLOCK;

    assign a_base[0] = oNODE1_BASE;  assign a_base[1] = oNODE2_BASE;
    assign a_base[2] = oNODE3_BASE;  assign a_base[3] = oNODE4_BASE;
    assign a_size[0] = oNODE1_SIZE;  assign a_size[1] = oNODE2_SIZE;
    assign a_size[2] = oNODE3_SIZE;  assign a_size[3] = oNODE4_SIZE;
    assign a_prio[0] = oNODE1_PRIORITY;  assign a_prio[1] = oNODE2_PRIORITY;
    assign a_prio[2] = oNODE3_PRIORITY;  assign a_prio[3] = oNODE4_PRIORITY;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [9:0] a);
        logic [9:0] off;
        if (a == 10'h000) return m_cnt;
        if (a == 10'h004) return m_total;
        off = a - 10'h100;
        if (off[9:5] > 5'd3) return 32'hBAD0_0000;
        return a[2] ? m_prio[off[6:5]] : m_size[off[6:5]];
    endfunction

    function automatic logic [31:0] exp_addr(input int k);
        if (k == 0) return 32'h000;
        if (k == 1) return 32'h004;
        return 32'h100 + 32'h20 * ((k - 2) / 2) + 32'h4 * ((k - 2) % 2);
    endfunction

    task automatic load_case1();
        m_cnt = 4; m_total = 32'hE00;
        m_size[0] = 32'h100; m_size[1] = 32'h200; m_size[2] = 32'h300; m_size[3] = 32'h400;
        m_prio[0] = 32'hABCD_EF01; m_prio[1] = 32'h1234_5602;
        m_prio[2] = 32'hFFFF_FF03; m_prio[3] = 32'h0000_0104;
        e_base[0] = 32'h400; e_base[1] = 32'h500; e_base[2] = 32'h700; e_base[3] = 32'hA00;
        e_size[0] = 32'h100; e_size[1] = 32'h200; e_size[2] = 32'h300; e_size[3] = 32'h400;
        e_prio[0] = 8'h01; e_prio[1] = 8'h02; e_prio[2] = 8'h03; e_prio[3] = 8'h04;
        e_valid = 4'hF;
    endtask

    task automatic clear_expect();
        for (int i = 0; i < 4; i++) begin
            e_base[i] = 32'd0; e_size[i] = 32'd0; e_prio[i] = 8'd0;
        end
        e_valid = 4'h0;
    endtask

    task automatic check_nodes();
        chk("node_valid", 32'(oNODE_VALID), 32'(e_valid));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("node%0d_base", i + 1), a_base[i], e_base[i]);
            chk($sformatf("node%0d_size", i + 1), a_size[i], e_size[i]);
            chk($sformatf("node%0d_prio", i + 1), 32'(a_prio[i]), 32'(e_prio[i]));
        end
    endtask

    // Start a scan and act as the memory until oDONE, a timeout or an abort
    task automatic applyStimulus(input int busy, input int lat, input bit hold_start,
                                 input int abort_at);
        int   bcnt = 0;
        int   lcnt = 0;
        bit   in_req = 0;
        bit   pend = 0;
        logic [9:0] cur = 10'd0;
        nreads = 0;
        done_seen = 0;
        @(negedge iCLOCK);
        iSTART = 1'b1;
        @(negedge iCLOCK);
        if (!hold_start) iSTART = 1'b0;
        chk("busy_after_start", 32'(oBUSY), 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iRD_VALID = 1'b0;
            iREQ_BUSY = 1'b0;
            iRD_DATA  = 32'hDEAD_BEEF;
            if (oDONE) begin
                done_seen = 1;
                break;
            end
            if (pend) begin
                if (lat >= 0 && lcnt == 0) begin
                    iRD_VALID = 1'b1;
                    iRD_DATA  = mem_read(cur);
                    pend      = 0;
                end else if (lcnt > 0) begin
                    lcnt--;
                end
            end else if (oREQ) begin
                if (!in_req) begin
                    in_req = 1;
                    bcnt   = busy;
                    cur    = oREQ_ADDR;
                    if (nreads < 16) addr_log[nreads] = oREQ_ADDR;
                    if (nreads == abort_at) begin
                        iRESET = 1'b1;
                        @(negedge iCLOCK);
                        iRESET = 1'b0;
                        iSTART = 1'b0;
                        return;
                    end
                end else begin
                    chk("req_addr_stable", 32'(oREQ_ADDR), 32'(cur));
                end
                if (bcnt > 0) begin
                    iREQ_BUSY = 1'b1;
                    iRD_VALID = 1'b1;
                    bcnt--;
                end else begin
                    in_req = 0;
                    nreads++;
                    if (lat == 0) begin
                        iRD_VALID = 1'b1;
                        iRD_DATA  = mem_read(cur);
                    end else begin
                        pend = 1;
                        lcnt = (lat > 0) ? lat - 1 : 0;
                    end
                end
            end else if (in_req) begin
                chk("req_held_while_busy", 32'(oREQ), 1);
                in_req = 0;
            end
            @(negedge iCLOCK);
        end
        iSTART = 1'b0;
    endtask

    // Verify the done cycle, the read sequence and the held result
    task automatic checkOutput(input logic [1:0] ecode, input int ereads);
        chk("done_seen", 32'(done_seen), 1);
        if (done_seen) begin
            chk("done_err_code", 32'(oERR_CODE), 32'(ecode));
            chk("done_error", 32'(oERROR), 32'(ecode != 2'd0));
            chk("done_busy", 32'(oBUSY), 1);
        end
        chk("read_count", 32'(nreads), 32'(ereads));
        for (int k = 0; k < nreads && k < 16; k++)
            chk($sformatf("addr_seq%0d", k), 32'(addr_log[k]), exp_addr(k));
        iRD_VALID = 1'b0;
        iSTART = 1'b0;
        @(negedge iCLOCK);
        chk("done_one_cycle", 32'(oDONE), 0);
        chk("idle_not_busy", 32'(oBUSY), 0);
        chk("held_err_code", 32'(oERR_CODE), 32'(ecode));
        chk("held_error", 32'(oERROR), 32'(ecode != 2'd0));
        check_nodes();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge iCLOCK);
        clear_expect();
        chk("rst_busy", 32'(oBUSY), 0);
        chk("rst_done", 32'(oDONE), 0);
        chk("rst_req", 32'(oREQ), 0);
        chk("rst_addr", 32'(oREQ_ADDR), 0);
        chk("rst_err", 32'(oERR_CODE), 0);
        check_nodes();
        iRESET = 1'b0;

        $display("[TB] case 1: four nodes, zero-latency responder");
        load_case1();
        applyStimulus(0, 0, 0, -1);
        checkOutput(2'd0, 10);

        $display("[TB] case 3: total mismatch");
        m_total = 32'hE04;
        applyStimulus(0, 1, 0, -1);
        checkOutput(2'd2, 10);

        $display("[TB] case 2: two nodes, start held through done");
        m_cnt = 2; m_total = 32'h1420;
        m_size[0] = 32'h1000; m_size[1] = 32'h20;
        m_prio[0] = 32'h0000_007F; m_prio[1] = 32'hFFFF_FF80;
        clear_expect();
        e_base[0] = 32'h400;  e_base[1] = 32'h1400;
        e_size[0] = 32'h1000; e_size[1] = 32'h20;
        e_prio[0] = 8'h7F;    e_prio[1] = 8'h80;
        e_valid = 4'h3;
        applyStimulus(0, 1, 1, -1);
        checkOutput(2'd0, 6);

        $display("[TB] case 4: bad node counts");
        m_cnt = 0;
        clear_expect();
        applyStimulus(0, 0, 0, -1);
        checkOutput(2'd1, 1);
        m_cnt = 5;
        applyStimulus(1, 2, 0, -1);
        checkOutput(2'd1, 1);

        $display("[TB] case 5: busy stalls with 0 and 2 cycle responses");
        load_case1();
        applyStimulus(3, 0, 0, -1);
        checkOutput(2'd0, 10);
        applyStimulus(3, 2, 0, -1);
        checkOutput(2'd0, 10);

        $display("[TB] case 6: reset during node 2 read");
        applyStimulus(1, 2, 0, 4);
        chk("abort_addr", 32'(addr_log[4]), 32'h120);
        clear_expect();
        chk("abort_busy", 32'(oBUSY), 0);
        chk("abort_req", 32'(oREQ), 0);
        chk("abort_addr_out", 32'(oREQ_ADDR), 0);
        chk("abort_err", 32'(oERR_CODE), 0);
        check_nodes();
        repeat (3) begin
            @(negedge iCLOCK);
            chk("abort_no_done", 32'(oDONE), 0);
        end
        load_case1();
        applyStimulus(0, 0, 0, -1);
        checkOutput(2'd0, 10);

`ifdef GCI_SCAN_TIMEOUT_EN
        $display("[TB] case 7: silent memory triggers watchdog");
        clear_expect();
        applyStimulus(0, -1, 0, -1);
        checkOutput(2'd3, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
